// File: rtl/cle_pkg.sv
// Shared types and default geometry for the label read-back path.
// Design-wide option: CLE_CHECK_EN enables the ROM compare in cle_label_reader.
package cle_pkg;

  localparam int unsigned IMG_W  = 32;
  localparam int unsigned IMG_H  = 32;
  localparam int unsigned LBL_W  = 8;

  localparam int unsigned PIX    = IMG_W * IMG_H;
  localparam int unsigned BYTES  = PIX / 8;
  localparam int unsigned ADDR_W = $clog2(PIX);
  localparam int unsigned IDX_W  = $clog2(BYTES);
  localparam int unsigned CNT_W  = $clog2(PIX + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StOut,
    StDone
  } state_e;

endpackage

// File: rtl/cle_byte_packer.sv
// Shifts one foreground bit per label into a byte, first pixel ending in bit 7.
module cle_byte_packer #(
  parameter int unsigned LBL_W = cle_pkg::LBL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic [LBL_W-1:0] i_lbl,
  output logic             o_fg,
  output logic [7:0]       o_byte_next
);

  logic [7:0] r_sr;

  assign o_fg        = |i_lbl;
  assign o_byte_next = {r_sr[6:0], o_fg};

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_sr <= 8'h00;
    end else if (i_shift) begin
      r_sr <= o_byte_next;
    end
  end

endmodule

// File: rtl/cle_label_reader.sv
// Scans the label SRAM, re-packs it to 1 bpp bytes and streams them out with stats.
// Optional macro CLE_CHECK_EN: compares each packed byte against the source ROM.
module cle_label_reader #(
  parameter int unsigned IMG_W = cle_pkg::IMG_W,
  parameter int unsigned IMG_H = cle_pkg::IMG_H,
  parameter int unsigned LBL_W = cle_pkg::LBL_W,
  localparam int unsigned AW   = $clog2(IMG_W * IMG_H),
  localparam int unsigned IW   = $clog2(IMG_W * IMG_H / 8),
  localparam int unsigned CW   = $clog2(IMG_W * IMG_H + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LBL_W-1:0] sram_q,
  output logic [AW-1:0]    sram_a,
  output logic [LBL_W-1:0] sram_d,
  output logic             sram_wen,
  input  logic [7:0]       rom_q,
  output logic [IW-1:0]    rom_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [IW-1:0]    out_idx,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    fg_count,
  output logic [LBL_W-1:0] max_label,
  output logic [7:0]       mismatch_cnt,
  output logic [IW-1:0]    first_mm_idx
);
  import cle_pkg::*;

  localparam logic [IW-1:0] LastIdx = IW'(IMG_W * IMG_H / 8 - 1);

  state_e           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [3:0]       r_c, w_c_nxt;
  logic [7:0]       r_out_data, w_out_data_nxt;
  logic [CW-1:0]    r_fg, w_fg_nxt;
  logic [LBL_W-1:0] r_max, w_max_nxt;
  logic             w_scan_start;
  logic             w_byte_done;
  logic             w_pk_shift;
  logic             w_pk_fg;
  logic [7:0]       w_pk_byte;

  cle_byte_packer #(
    .LBL_W (LBL_W)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_scan_start),
    .i_shift     (w_pk_shift),
    .i_lbl       (sram_q),
    .o_fg        (w_pk_fg),
    .o_byte_next (w_pk_byte)
  );

  // Pixel c is addressed at count c; its data arrives, and is packed, at count c+1.
  assign sram_a    = {r_idx, r_c[2:0]};
  assign sram_d    = '0;
  assign sram_wen  = 1'b1;
  assign out_valid = (r_state == StOut);
  assign out_data  = r_out_data;
  assign out_idx   = r_idx;
  assign busy      = (r_state == StRead) || (r_state == StOut);
  assign done      = (r_state == StDone);
  assign fg_count  = r_fg;
  assign max_label = r_max;

  assign w_scan_start = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_byte_done  = (r_state == StRead) && (r_c == 4'd8);
  assign w_pk_shift   = (r_state == StRead) && (r_c != 4'd0);

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_c_nxt        = r_c;
    w_out_data_nxt = r_out_data;
    w_fg_nxt       = r_fg;
    w_max_nxt      = r_max;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt = StRead;
          w_idx_nxt   = '0;
          w_c_nxt     = 4'd0;
          w_fg_nxt    = '0;
          w_max_nxt   = '0;
        end
      end
      StRead: begin
        w_c_nxt = r_c + 4'd1;
        if (w_pk_shift) begin
          if (w_pk_fg) w_fg_nxt = r_fg + 1'b1;
          if (sram_q > r_max) w_max_nxt = sram_q;
        end
        if (w_byte_done) begin
          w_c_nxt        = 4'd0;
          w_out_data_nxt = w_pk_byte;
          w_state_nxt    = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (r_idx == LastIdx) begin
            w_state_nxt = StDone;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = StRead;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_c        <= 4'd0;
      r_out_data <= 8'h00;
      r_fg       <= '0;
      r_max      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_c        <= w_c_nxt;
      r_out_data <= w_out_data_nxt;
      r_fg       <= w_fg_nxt;
      r_max      <= w_max_nxt;
    end
  end

`ifdef CLE_CHECK_EN
  logic [7:0]    r_mm_cnt;
  logic [IW-1:0] r_first_mm;

  assign rom_a        = r_idx;
  assign mismatch_cnt = r_mm_cnt;
  assign first_mm_idx = r_first_mm;

  // rom_q for this byte has settled by the time the last pixel is packed.
  always_ff @(posedge clk) begin
    if (reset || w_scan_start) begin
      r_mm_cnt   <= 8'h00;
      r_first_mm <= '0;
    end else if (w_byte_done && (w_pk_byte != rom_q)) begin
      if (r_mm_cnt != 8'hFF) r_mm_cnt <= r_mm_cnt + 8'd1;
      if (r_mm_cnt == 8'h00) r_first_mm <= r_idx;
    end
  end
`else
  logic w_unused_rom;

  assign w_unused_rom = ^rom_q;
  assign rom_a        = '0;
  assign mismatch_cnt = 8'h00;
  assign first_mm_idx = '0;
`endif

endmodule
